// File: rtl/pulse_conditioner.sv
// Pulse counter front end: synchronise, debounce, pick an edge type and emit
// one-cycle count enables, framed by a window sequencer that clears the counter.
module pulse_conditioner #(
  parameter int SYNC_STAGES = 2,
  parameter int DEB_W       = 4,
  parameter int WIN_W       = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             pulse_in,
  input  logic [1:0]       edge_sel,
  input  logic [DEB_W-1:0] deb_len,
  input  logic [WIN_W-1:0] win_len,
  input  logic             start,
  input  logic             stop,
  output logic             count_en,
  output logic             count_clr,
  output logic             win_done,
  output logic             glitch,
  output logic             busy
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CLEAR = 2'd1,
    ARMED = 2'd2
  } state_t;

  state_t                 state;
  logic [SYNC_STAGES-1:0] sync;
  logic                   s;
  logic                   f;
  logic [DEB_W-1:0]       dcnt;
  logic [WIN_W-1:0]       wcnt;
  logic                   edge_match;

  assign s = sync[SYNC_STAGES-1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sync <= '0;
    else        sync <= {sync[SYNC_STAGES-2:0], pulse_in};
  end

  // On an update event the new filtered level equals s, so s decides the edge direction.
  always_comb begin
    edge_match = 1'b0;
    case (edge_sel)
      2'b00:   edge_match = s;
      2'b01:   edge_match = !s;
      2'b10:   edge_match = 1'b1;
      default: edge_match = 1'b0;
    endcase
  end

  // >= rather than == so a deb_len lowered below a running count still fires next cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      f        <= 1'b0;
      dcnt     <= '0;
      glitch   <= 1'b0;
      count_en <= 1'b0;
    end else begin
      glitch   <= 1'b0;
      count_en <= 1'b0;
      if (s == f) begin
        dcnt   <= '0;
        glitch <= (dcnt != '0);
      end else if (dcnt >= deb_len) begin
        f        <= s;
        dcnt     <= '0;
        count_en <= (state == ARMED) && edge_match;
      end else begin
        dcnt <= dcnt + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      wcnt      <= '0;
      count_clr <= 1'b0;
      win_done  <= 1'b0;
      busy      <= 1'b0;
    end else begin
      count_clr <= 1'b0;
      win_done  <= 1'b0;
      if (stop) begin
        state <= IDLE;
        busy  <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            if (start) begin
              state     <= CLEAR;
              count_clr <= 1'b1;
              busy      <= 1'b1;
            end
          end
          CLEAR: begin
            state <= ARMED;
            wcnt  <= win_len;
          end
          ARMED: begin
            if (start) begin
              state     <= CLEAR;
              count_clr <= 1'b1;
            end else if (win_len != '0 && wcnt == 1) begin
              state     <= CLEAR;
              count_clr <= 1'b1;
              win_done  <= 1'b1;
            end else if (win_len != '0) begin
              wcnt <= wcnt - 1'b1;
            end
          end
          default: begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_pulse_conditioner.sv
// Directed bench for pulse_conditioner with a 3-bit downstream counter model.
module tb_pulse_conditioner;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       pulse_in;
  logic [1:0] edge_sel;
  logic [3:0] deb_len;
  logic [7:0] win_len;
  logic       start;
  logic       stop;
  logic       count_en;
  logic       count_clr;
  logic       win_done;
  logic       glitch;
  logic       busy;

  int errors = 0;
  int checks = 0;
  int en_total = 0;
  int glitch_total = 0;
  int clr_total = 0;
  logic [2:0] ds_cnt;

  pulse_conditioner #(.SYNC_STAGES(2), .DEB_W(4), .WIN_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .pulse_in(pulse_in), .edge_sel(edge_sel),
    .deb_len(deb_len), .win_len(win_len), .start(start), .stop(stop),
    .count_en(count_en), .count_clr(count_clr), .win_done(win_done),
    .glitch(glitch), .busy(busy)
  );

  always #5 clk = ~clk;

  // Downstream 3-bit pulse counter; clear wins over enable.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n)         ds_cnt <= 3'd0;
    else if (count_clr) ds_cnt <= 3'd0;
    else if (count_en)  ds_cnt <= ds_cnt + 3'd1;
  end

  always @(negedge clk) begin
    en_total     <= en_total + int'(count_en);
    glitch_total <= glitch_total + int'(glitch);
    clr_total    <= clr_total + int'(count_clr);
  end

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; pulse_in = 1'b0; edge_sel = 2'b00; deb_len = 4'd0;
    win_len = 8'd0; start = 1'b0; stop = 1'b0;
    tick(2);
    checks++; if (count_en !== 1'b0)  begin errors++; $display("FAIL reset_count_en got=%b exp=0", count_en); end
    checks++; if (count_clr !== 1'b0) begin errors++; $display("FAIL reset_count_clr got=%b exp=0", count_clr); end
    checks++; if (win_done !== 1'b0)  begin errors++; $display("FAIL reset_win_done got=%b exp=0", win_done); end
    checks++; if (glitch !== 1'b0)    begin errors++; $display("FAIL reset_glitch got=%b exp=0", glitch); end
    checks++; if (busy !== 1'b0)      begin errors++; $display("FAIL reset_busy got=%b exp=0", busy); end
    #3 rst_n = 1'b1;
    tick(2);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_exit_idle busy got=%b exp=0", busy); end
  endtask

  task automatic test_rising();
    int en0;
    start = 1'b1;
    tick();
    start = 1'b0;
    checks++; if (count_clr !== 1'b1) begin errors++; $display("FAIL start_clear count_clr got=%b exp=1", count_clr); end
    checks++; if (win_done !== 1'b0)  begin errors++; $display("FAIL start_clear win_done got=%b exp=0", win_done); end
    checks++; if (busy !== 1'b1)      begin errors++; $display("FAIL start_busy got=%b exp=1", busy); end
    tick();
    checks++; if (count_clr !== 1'b0) begin errors++; $display("FAIL armed count_clr got=%b exp=0", count_clr); end
    tick(2);
    en0 = en_total;
    pulse_in = 1'b1;
    tick();
    checks++; if (count_en !== 1'b0) begin errors++; $display("FAIL rise_lat_k count_en got=%b exp=0", count_en); end
    tick();
    checks++; if (count_en !== 1'b0) begin errors++; $display("FAIL rise_lat_k1 count_en got=%b exp=0", count_en); end
    tick();
    checks++; if (count_en !== 1'b1) begin errors++; $display("FAIL rise_lat_k2 count_en got=%b exp=1", count_en); end
    tick();
    checks++; if (count_en !== 1'b0) begin errors++; $display("FAIL rise_one_cycle count_en got=%b exp=0", count_en); end
    tick();
    pulse_in = 1'b0;
    tick(6);
    checks++; if (en_total - en0 !== 1) begin errors++; $display("FAIL rise_total got=%0d exp=1", en_total - en0); end
  endtask

  task automatic test_debounce();
    int en0, gl0;
    deb_len = 4'd3;
    en0 = en_total; gl0 = glitch_total;
    pulse_in = 1'b1;
    tick(2);
    pulse_in = 1'b0;
    tick(8);
    checks++; if (en_total - en0 !== 0)      begin errors++; $display("FAIL glitch_no_count got=%0d exp=0", en_total - en0); end
    checks++; if (glitch_total - gl0 !== 1)  begin errors++; $display("FAIL glitch_pulses got=%0d exp=1", glitch_total - gl0); end
    en0 = en_total; gl0 = glitch_total;
    pulse_in = 1'b1;
    tick(5);
    checks++; if (count_en !== 1'b0) begin errors++; $display("FAIL deb_lat_k4 count_en got=%b exp=0", count_en); end
    tick();
    checks++; if (count_en !== 1'b1) begin errors++; $display("FAIL deb_lat_k5 count_en got=%b exp=1", count_en); end
    pulse_in = 1'b0;
    tick();
    checks++; if (count_en !== 1'b0) begin errors++; $display("FAIL deb_one_cycle count_en got=%b exp=0", count_en); end
    tick(10);
    checks++; if (en_total - en0 !== 1)     begin errors++; $display("FAIL deb_total got=%0d exp=1", en_total - en0); end
    checks++; if (glitch_total - gl0 !== 0) begin errors++; $display("FAIL deb_no_glitch got=%0d exp=0", glitch_total - gl0); end
    deb_len = 4'd0;
  endtask

  task automatic test_both_none();
    int en0;
    edge_sel = 2'b10;
    en0 = en_total;
    for (int i = 0; i < 8; i++) begin
      pulse_in = ~pulse_in;
      tick(4);
    end
    checks++; if (en_total - en0 !== 8) begin errors++; $display("FAIL both_edges got=%0d exp=8", en_total - en0); end
    edge_sel = 2'b11;
    en0 = en_total;
    for (int i = 0; i < 8; i++) begin
      pulse_in = ~pulse_in;
      tick(4);
    end
    checks++; if (en_total - en0 !== 0) begin errors++; $display("FAIL no_edges got=%0d exp=0", en_total - en0); end
    edge_sel = 2'b01;
    en0 = en_total;
    for (int i = 0; i < 4; i++) begin
      pulse_in = ~pulse_in;
      tick(4);
    end
    checks++; if (en_total - en0 !== 2) begin errors++; $display("FAIL falling_edges got=%0d exp=2", en_total - en0); end
    edge_sel = 2'b00;
  endtask

  task automatic test_window();
    win_len = 8'd10;
    start = 1'b1;
    tick();
    start = 1'b0;
    checks++; if (count_clr !== 1'b1 || win_done !== 1'b0) begin
      errors++; $display("FAIL win_restart clr/done got=%b%b exp=10", count_clr, win_done);
    end
    for (int w = 0; w < 3; w++) begin
      for (int i = 0; i < 11; i++) begin
        pulse_in = (i == 0 || i == 3 || i == 6);
        tick();
        if (i == 4) begin
          checks++; if (count_clr !== 1'b0) begin errors++; $display("FAIL win_mid count_clr w=%0d got=%b exp=0", w, count_clr); end
        end
        if (i == 10) begin
          checks++; if (count_clr !== 1'b1 || win_done !== 1'b1) begin
            errors++; $display("FAIL win_expiry w=%0d clr/done got=%b%b exp=11", w, count_clr, win_done);
          end
          checks++; if (ds_cnt !== 3'd3) begin errors++; $display("FAIL win_count w=%0d got=%0d exp=3", w, ds_cnt); end
        end
      end
    end
    pulse_in = 1'b0;
    stop = 1'b1;
    tick();
    stop = 1'b0;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL stop_busy got=%b exp=0", busy); end
    tick(4);
  endtask

  task automatic test_clear_drop();
    int en0;
    win_len = 8'd0;
    en0 = en_total;
    pulse_in = 1'b1;
    tick();
    start = 1'b1;
    tick();
    start = 1'b0;
    checks++; if (count_clr !== 1'b1) begin errors++; $display("FAIL drop_clear count_clr got=%b exp=1", count_clr); end
    tick();
    checks++; if (count_en !== 1'b0) begin errors++; $display("FAIL drop_in_clear count_en got=%b exp=0", count_en); end
    tick(3);
    pulse_in = 1'b0;
    tick(4);
    checks++; if (en_total - en0 !== 0) begin errors++; $display("FAIL drop_total got=%0d exp=0", en_total - en0); end
  endtask

  task automatic test_back_to_back();
    win_len = 8'd10;
    start = 1'b1;
    tick();
    start = 1'b0;
    tick(4);
    start = 1'b1;
    tick();
    start = 1'b0;
    checks++; if (count_clr !== 1'b1 || win_done !== 1'b0) begin
      errors++; $display("FAIL armed_restart clr/done got=%b%b exp=10", count_clr, win_done);
    end
    tick(10);
    checks++; if (count_clr !== 1'b0) begin errors++; $display("FAIL restart_period_early got=%b exp=0", count_clr); end
    tick();
    checks++; if (count_clr !== 1'b1 || win_done !== 1'b1) begin
      errors++; $display("FAIL restart_period clr/done got=%b%b exp=11", count_clr, win_done);
    end
    tick(3);
    start = 1'b1; stop = 1'b1;
    tick();
    start = 1'b0; stop = 1'b0;
    checks++; if (busy !== 1'b0 || count_clr !== 1'b0) begin
      errors++; $display("FAIL start_stop busy/clr got=%b%b exp=00", busy, count_clr);
    end
    tick(3);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL start_stop_stay got=%b exp=0", busy); end
  endtask

  task automatic test_reset_mid();
    int clr0, gl0;
    deb_len = 4'd3;
    win_len = 8'd10;
    start = 1'b1;
    tick();
    start = 1'b0;
    tick(3);
    pulse_in = 1'b1;
    tick(4);
    #2 rst_n = 1'b0;
    #1;
    checks++; if ({count_en, count_clr, win_done, glitch, busy} !== 5'b0) begin
      errors++; $display("FAIL reset_mid outputs got=%b exp=00000", {count_en, count_clr, win_done, glitch, busy});
    end
    pulse_in = 1'b0;
    #2 rst_n = 1'b1;
    clr0 = clr_total; gl0 = glitch_total;
    tick(15);
    checks++; if (busy !== 1'b0)           begin errors++; $display("FAIL reset_mid_idle busy got=%b exp=0", busy); end
    checks++; if (clr_total - clr0 !== 0)  begin errors++; $display("FAIL reset_mid_no_clr got=%0d exp=0", clr_total - clr0); end
    checks++; if (glitch_total - gl0 !== 0) begin errors++; $display("FAIL reset_mid_no_glitch got=%0d exp=0", glitch_total - gl0); end
    start = 1'b1;
    tick();
    start = 1'b0;
    checks++; if (count_clr !== 1'b1 || busy !== 1'b1) begin
      errors++; $display("FAIL reset_mid_restart clr/busy got=%b%b exp=11", count_clr, busy);
    end
    tick(2);
  endtask

  initial begin
    test_reset();
    test_rising();
    test_debounce();
    test_both_none();
    test_window();
    test_clear_drop();
    test_back_to_back();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
